// File: rtl/ads1274_pkg.sv
// ads1274_pkg: shared frame geometry, averager state encoding and channel slicing helper.
package ads1274_pkg;

    localparam int ADS1274_CH       = 4;
    localparam int ADS1274_SAMPLE_W = 24;
    localparam int ADS1274_FRAME_W  = ADS1274_CH * ADS1274_SAMPLE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit offset of channel k inside a packed frame (ch0 occupies the low bits).
    function automatic int ch_offset(input int k);
        return k * ADS1274_SAMPLE_W;
    endfunction

endpackage

// File: rtl/ads1274_averager.sv
// ads1274_averager: averages 2^LOG2_N consecutive ADS1274 frames per channel and emits one
// decimated frame with a single-cycle valid strobe. One adder is shared across the four
// channels, sweeping ch0..ch3 on the four cycles following each accepted frame.
// LOG2_N is meaningful in the range 0..8; the output sample width is fixed at 24 bits.
module ads1274_averager
    import ads1274_pkg::*;
#(
    parameter int LOG2_N = 4
) (
    input  logic                       Clk,
    input  logic                       nReset,
    input  logic                       Clear,
    input  logic                       InValid,
    input  logic [ADS1274_FRAME_W-1:0] DataIn,
    output logic [ADS1274_FRAME_W-1:0] DataOut,
    output logic                       OutValid,
    output logic                       Overrun,
    output logic [LOG2_N:0]            FrameCount
);

    localparam int              OUT_W          = ADS1274_SAMPLE_W;
    localparam int              ACC_W          = ADS1274_SAMPLE_W + LOG2_N;
    localparam logic [LOG2_N:0] FRAMES_PER_OUT = (LOG2_N + 1)'(1 << LOG2_N);
    localparam logic [1:0]      LAST_CH        = 2'(ADS1274_CH - 1);

    state_t                     state;
    state_t                     next_state;
    logic [ADS1274_FRAME_W-1:0] hold;
    logic [1:0]                 ch_idx;
    logic signed [ACC_W-1:0]    acc [ADS1274_CH];
    logic [OUT_W-1:0]           cur_sample;
    logic signed [ACC_W-1:0]    acc_sum;
    logic [LOG2_N:0]            frame_count_next;
    logic                       window_full;

    // Shared adder: sign-extend the held sample of the channel being swept and add it to its accumulator.
    always_comb begin
        cur_sample = hold[ch_offset(int'(ch_idx)) +: OUT_W];
        acc_sum    = acc[ch_idx] + ACC_W'($signed(cur_sample));
    end

    // Window bookkeeping: the frame finishing its sweep closes the window when the count reaches 2^LOG2_N.
    always_comb begin
        frame_count_next = FrameCount + 1'b1;
        window_full      = (frame_count_next == FRAMES_PER_OUT);
    end

    // State register.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: Clear always returns to IDLE; frames are only accepted in IDLE.
    always_comb begin
        next_state = state;
        if (Clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        next_state = ACC;
                    end
                end
                ACC: begin
                    if (ch_idx == LAST_CH) begin
                        next_state = window_full ? DONE : IDLE;
                    end
                end
                DONE: begin
                    next_state = IDLE;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Datapath: frame capture, channel sweep, window close, and sticky drop detection.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            hold       <= '0;
            ch_idx     <= '0;
            FrameCount <= '0;
            DataOut    <= '0;
            OutValid   <= 1'b0;
            Overrun    <= 1'b0;
            for (int k = 0; k < ADS1274_CH; k++) begin
                acc[k] <= '0;
            end
        end else begin
            OutValid <= 1'b0;
            if (Clear) begin
                ch_idx     <= '0;
                FrameCount <= '0;
                for (int k = 0; k < ADS1274_CH; k++) begin
                    acc[k] <= '0;
                end
            end else begin
                if (InValid && (state != IDLE)) begin
                    Overrun <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (InValid) begin
                            hold   <= DataIn;
                            ch_idx <= '0;
                        end
                    end
                    ACC: begin
                        acc[ch_idx] <= acc_sum;
                        ch_idx      <= ch_idx + 2'd1;
                        if (ch_idx == LAST_CH) begin
                            FrameCount <= frame_count_next;
                        end
                    end
                    DONE: begin
                        for (int k = 0; k < ADS1274_CH; k++) begin
                            DataOut[ch_offset(k) +: OUT_W] <= OUT_W'(acc[k] >>> LOG2_N);
                            acc[k] <= '0;
                        end
                        OutValid   <= 1'b1;
                        FrameCount <= '0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ads1274_averager.sv
// tb_ads1274_averager: three averagers (LOG2_N = 2, 0, 4) share one stimulus stream and are
// compared every cycle against a frame-level reference model, plus directed table and corner cases.
module tb_ads1274_averager;
    import ads1274_pkg::*;

    localparam int NDUT = 3;

    logic                       Clk;
    logic                       nReset;
    logic                       Clear;
    logic                       InValid;
    logic [ADS1274_FRAME_W-1:0] DataIn;
    logic [ADS1274_FRAME_W-1:0] dout [NDUT];
    logic                       oval [NDUT];
    logic                       ovr  [NDUT];
    logic [2:0]                 fc2;
    logic [0:0]                 fc0;
    logic [4:0]                 fc4;

    longint cyc = 0;
    int     errors;
    int     checks;

    // Reference model state, one entry per DUT.
    longint                     msum [NDUT][4];
    int                         mcount [NDUT];
    longint                     busy_until [NDUT];
    longint                     pend_at [NDUT];
    logic [ADS1274_FRAME_W-1:0] pend_val [NDUT];
    logic [ADS1274_FRAME_W-1:0] exp_out [NDUT];
    logic                       exp_ovr [NDUT];
    int                         pulses [NDUT];
    longint                     last_pulse [NDUT];

    typedef struct packed {
        logic [3:0][95:0] frames;
        logic [95:0]      expected;
    } avg_vec_t;

    avg_vec_t vecs [3];

    ads1274_averager #(.LOG2_N(2)) dut_n2 (
        .Clk(Clk), .nReset(nReset), .Clear(Clear), .InValid(InValid), .DataIn(DataIn),
        .DataOut(dout[0]), .OutValid(oval[0]), .Overrun(ovr[0]), .FrameCount(fc2)
    );

    ads1274_averager #(.LOG2_N(0)) dut_n0 (
        .Clk(Clk), .nReset(nReset), .Clear(Clear), .InValid(InValid), .DataIn(DataIn),
        .DataOut(dout[1]), .OutValid(oval[1]), .Overrun(ovr[1]), .FrameCount(fc0)
    );

    ads1274_averager #(.LOG2_N(4)) dut_n4 (
        .Clk(Clk), .nReset(nReset), .Clear(Clear), .InValid(InValid), .DataIn(DataIn),
        .DataOut(dout[2]), .OutValid(oval[2]), .Overrun(ovr[2]), .FrameCount(fc4)
    );

    // 100 MHz bench clock; inputs change and outputs are sampled on the falling edge.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Rising-edge index used to schedule expected output pulses.
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic int l2Of(input int d);
        case (d)
            0:       return 2;
            1:       return 0;
            default: return 4;
        endcase
    endfunction

    function automatic int fcount(input int d);
        case (d)
            0:       return int'(fc2);
            1:       return int'(fc0);
            default: return int'(fc4);
        endcase
    endfunction

    function automatic logic [95:0] pack4(input int c0, input int c1, input int c2, input int c3);
        return {c3[23:0], c2[23:0], c1[23:0], c0[23:0]};
    endfunction

    function automatic longint toSigned(input logic [23:0] s);
        longint v;
        v = longint'(s);
        if (v >= 64'sh800000) v = v - 64'sh1000000;
        return v;
    endfunction

    function automatic longint floorDiv(input longint a, input longint n);
        longint q;
        q = a / n;
        if ((a % n != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic compareValue(input string name, input int d, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d (LOG2_N=%0d): got %h, expected %h", name, d, l2Of(d), act, exp);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < NDUT; d++) begin
            for (int k = 0; k < 4; k++) msum[d][k] = 0;
            mcount[d]     = 0;
            busy_until[d] = 0;
            pend_at[d]    = -1;
            pend_val[d]   = '0;
            exp_out[d]    = '0;
            exp_ovr[d]    = 1'b0;
        end
    endtask

    // Frame-level rules: a frame is taken only when the block is free (5 cycles after a frame,
    // 6 after a window-closing one); the average appears 5 edges after the closing frame.
    task automatic modelStep(input bit clr, input bit inv, input logic [95:0] data, input longint e);
        for (int d = 0; d < NDUT; d++) begin
            if (clr) begin
                for (int k = 0; k < 4; k++) msum[d][k] = 0;
                mcount[d]     = 0;
                busy_until[d] = e + 1;
                if (pend_at[d] >= e) pend_at[d] = -1;
            end else if (inv) begin
                if (e < busy_until[d]) begin
                    exp_ovr[d] = 1'b1;
                end else begin
                    for (int k = 0; k < 4; k++) msum[d][k] += toSigned(data[k*24 +: 24]);
                    mcount[d]++;
                    if (mcount[d] == (1 << l2Of(d))) begin
                        for (int k = 0; k < 4; k++) begin
                            pend_val[d][k*24 +: 24] = 24'(floorDiv(msum[d][k], 64'(1) << l2Of(d)));
                            msum[d][k] = 0;
                        end
                        mcount[d]     = 0;
                        pend_at[d]    = e + 5;
                        busy_until[d] = e + 6;
                    end else begin
                        busy_until[d] = e + 5;
                    end
                end
            end
        end
    endtask

    task automatic checkOutput(input longint e);
        bit ev;
        for (int d = 0; d < NDUT; d++) begin
            ev = (pend_at[d] == e);
            if (ev) exp_out[d] = pend_val[d];
            compareValue("OutValid", d, 96'(oval[d]), 96'(ev));
            compareValue("DataOut", d, dout[d], exp_out[d]);
            compareValue("Overrun", d, 96'(ovr[d]), 96'(exp_ovr[d]));
            if (e + 1 >= busy_until[d]) begin
                compareValue("FrameCount", d, 96'(fcount(d)), 96'(mcount[d]));
            end
            if (oval[d]) begin
                pulses[d]++;
                last_pulse[d] = e;
            end
        end
    endtask

    task automatic applyStimulus(input bit clr, input bit inv, input logic [95:0] data);
        longint e;
        e       = cyc;
        Clear   = clr;
        InValid = inv;
        DataIn  = data;
        modelStep(clr, inv, data, e);
        @(posedge Clk);
        @(negedge Clk);
        checkOutput(e);
    endtask

    task automatic sendFrame(input logic [95:0] data, input int gap);
        applyStimulus(1'b0, 1'b1, data);
        repeat (gap - 1) applyStimulus(1'b0, 1'b0, '0);
    endtask

    task automatic checkResetValues(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            compareValue({tag, "_DataOut"}, d, dout[d], '0);
            compareValue({tag, "_OutValid"}, d, 96'(oval[d]), '0);
            compareValue({tag, "_Overrun"}, d, 96'(ovr[d]), '0);
            compareValue({tag, "_FrameCount"}, d, 96'(fcount(d)), '0);
        end
    endtask

    task automatic runRandom(input int n);
        bit          clr;
        bit          inv;
        logic [95:0] data;
        logic [23:0] ch;
        for (int i = 0; i < n; i++) begin
            clr = ($urandom_range(0, 49) == 0);
            inv = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 3))
                    0:       ch = 24'h7FFFFF;
                    1:       ch = 24'h800000;
                    default: ch = 24'($urandom);
                endcase
                data[k*24 +: 24] = ch;
            end
            applyStimulus(clr, inv, data);
        end
    endtask

    initial begin
        logic [95:0] lz [2];
        longint      t_last;

        errors  = 0;
        checks  = 0;
        nReset  = 1'b0;
        Clear   = 1'b0;
        InValid = 1'b0;
        DataIn  = '0;
        for (int d = 0; d < NDUT; d++) begin
            pulses[d]     = 0;
            last_pulse[d] = -100;
        end
        modelReset();

        repeat (3) @(negedge Clk);
        checkResetValues("reset");
        nReset = 1'b1;

        // Averaging table for the LOG2_N=2 instance, frames 10 cycles apart.
        for (int f = 0; f < 4; f++) begin
            vecs[0].frames[f] = pack4(100, -100, 'h7FFFFF, -'h800000);
            vecs[1].frames[f] = pack4(f + 1, -(f + 1), (f == 3) ? 'h7FFFFE : 'h7FFFFF,
                                      (f == 3) ? -'h7FFFFF : -'h800000);
            vecs[2].frames[f] = pack4((f == 3) ? 3 : 0, (f == 0) ? -1 : 0, 5, -7);
        end
        vecs[0].expected = pack4(100, -100, 'h7FFFFF, -'h800000);
        vecs[1].expected = pack4(2, -3, 'h7FFFFE, -'h800000);
        vecs[2].expected = pack4(0, -1, 5, -7);

        for (int v = 0; v < 3; v++) begin
            pulses[0] = 0;
            t_last    = 0;
            for (int f = 0; f < 4; f++) begin
                t_last = cyc;
                sendFrame(vecs[v].frames[f], 10);
            end
            compareValue("tbl_DataOut", 0, dout[0], vecs[v].expected);
            compareValue("tbl_pulses", 0, 96'(pulses[0]), 96'(1));
            compareValue("tbl_latency", 0, 96'(last_pulse[0] - t_last), 96'(5));
            compareValue("tbl_FrameCount", 0, 96'(fc2), '0);
        end

        // Clear mid-sweep after 3 of 4 frames, with a same-cycle InValid that must be ignored.
        pulses[0] = 0;
        sendFrame(pack4(50, 50, 50, 50), 6);
        sendFrame(pack4(50, 50, 50, 50), 6);
        sendFrame(pack4(50, 50, 50, 50), 2);
        applyStimulus(1'b1, 1'b1, pack4(999, 999, 999, 999));
        compareValue("clr_DataOut_held", 0, dout[0], vecs[2].expected);
        compareValue("clr_no_Overrun", 0, 96'(ovr[0]), '0);
        compareValue("clr_FrameCount", 0, 96'(fc2), '0);
        repeat (4) sendFrame(pack4(8, 8, 8, 8), 6);
        compareValue("clr_pulses", 0, 96'(pulses[0]), 96'(1));
        compareValue("clr_DataOut", 0, dout[0], pack4(8, 8, 8, 8));

        // LOG2_N=0 passes every frame through with the 5-edge latency.
        lz[0] = 96'h000001_FFFFFF_800000_7FFFFF;
        lz[1] = pack4(-2, 0, 1, -1);
        for (int f = 0; f < 2; f++) begin
            applyStimulus(1'b0, 1'b1, lz[f]);
            repeat (5) applyStimulus(1'b0, 1'b0, '0);
            compareValue("l0_OutValid", 1, 96'(oval[1]), 96'(1));
            compareValue("l0_DataOut", 1, dout[1], lz[f]);
            applyStimulus(1'b0, 1'b0, '0);
        end

        // A frame 3 cycles after another is dropped; Overrun is sticky across windows.
        applyStimulus(1'b1, 1'b0, '0);
        sendFrame(pack4(10, 10, 10, 10), 3);
        compareValue("ovr_before", 0, 96'(ovr[0]), '0);
        sendFrame(pack4(1000, 1000, 1000, 1000), 3);
        repeat (3) sendFrame(pack4(10, 10, 10, 10), 6);
        compareValue("ovr_DataOut", 0, dout[0], pack4(10, 10, 10, 10));
        compareValue("ovr_set", 0, 96'(ovr[0]), 96'(1));
        repeat (4) sendFrame(pack4(20, 20, 20, 20), 6);
        compareValue("ovr_DataOut2", 0, dout[0], pack4(20, 20, 20, 20));
        compareValue("ovr_sticky", 0, 96'(ovr[0]), 96'(1));

        // Asynchronous reset while the sweep is on ch2, then a fresh 16-frame window.
        applyStimulus(1'b0, 1'b1, pack4(7, -7, 7, -7));
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0);
        nReset = 1'b0;
        #1;
        checkResetValues("async_reset");
        modelReset();
        @(posedge Clk);
        @(negedge Clk);
        nReset    = 1'b1;
        pulses[2] = 0;
        repeat (16) sendFrame(pack4(5, 5, 5, 5), 6);
        compareValue("rst_DataOut", 2, dout[2], pack4(5, 5, 5, 5));
        compareValue("rst_pulses", 2, 96'(pulses[2]), 96'(1));

        // Randomized traffic including Clears, drops and full-scale samples.
        runRandom(900);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ads1274_averager.md
Name: ads1274_averager

Overview:
- Downstream stage of the ADS1274 four-channel capture block. Consumes its 96-bit parallel frame (4 × 24-bit two's complement), one frame per frame-valid pulse.
- Accumulates 2^LOG2_N frames per channel. Emits a decimated, averaged 4-channel frame with a one-cycle valid strobe.
- Uses one shared 4-cycle time-multiplexed adder sweep per frame. Feeds logging/DSP logic at the reduced rate.

Parameters:
LOG2_N, 4, log2 of frames averaged per output; legal range 0..8
OUT_W, 24, output sample width per channel; fixed at 24 (not overridable)

Ports:
Clk  input  1  system clock, same domain as the capture block (max 50 MHz)
nReset  input  1  asynchronous active-low reset
Clear  input  1  synchronous; abandons the current average (see Behaviour)
InValid  input  1  single-cycle pulse; DataIn is stable in this cycle
DataIn  input  96  ch0=[23:0], ch1=[47:24], ch2=[71:48], ch3=[95:72]; 2's complement
DataOut  output  96  averaged frame, same channel packing
OutValid  output  1  single-cycle pulse when DataOut updates
Overrun  output  1  sticky; a frame was dropped
FrameCount  output  LOG2_N+1  frames accumulated in the current window (observability)

Behaviour:
- Clk and reset: single clock Clk; reset nReset is asynchronous and active-low.
- Reset values: DataOut=0, OutValid=0, Overrun=0, FrameCount=0, all accumulators=0, state=IDLE.
- Accumulators: four of width 24+LOG2_N, signed. Each 24-bit input is sign-extended before adding.
- No overflow is possible: worst case is 2^LOG2_N × 0x7FFFFF or × -0x800000.
- Registered frame: on InValid in IDLE, DataIn is captured into a 96-bit holding register and state goes to ACC with channel index 0.
- ACC state: processes one channel per cycle, ch0..ch3. Each cycle does acc[k] <= acc[k] + sext(hold[k]).
- After ch3, FrameCount increments:
  - if it reaches 2^LOG2_N, go to DONE;
  - otherwise go to IDLE.
- DONE state, one cycle:
  - DataOut[k] <= acc[k] >>> LOG2_N (arithmetic shift, keep low 24 bits; rounds toward -inf);
  - OutValid=1 for exactly this cycle's output register;
  - acc cleared, FrameCount=0;
  - return to IDLE.
- Latency: InValid sampled at edge t. ch0..ch3 are processed at edges t+1..t+4. DONE is at edge t+5, so OutValid is high between edges t+5 and t+6.
- Throughput: InValid is accepted only in IDLE. The minimum lossless spacing is 5 cycles, or 6 on a window-closing frame.
- Drop rule: InValid while in ACC or DONE drops the frame and sets Overrun. Overrun clears only on reset.
- LOG2_N=0: every frame yields an output equal to the input frame, with the same 5-cycle latency.
- Clear: has priority over everything except reset.
  - From any state: go to IDLE, zero accumulators and FrameCount, suppress OutValid.
  - DataOut and Overrun are held.
  - InValid in the same cycle as Clear is ignored, with no Overrun.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The first frame after reset starts a fresh window.
- DataOut holds its value between OutValid pulses. Consumers may sample any time after OutValid.

Decomposition:
- Shared package ads1274_pkg:
  - ADS1274_CH=4, ADS1274_SAMPLE_W=24, ADS1274_FRAME_W=96;
  - state encoding constants IDLE/ACC/DONE;
  - a channel-slice helper function (index → bit offset 24×k).
- Optional sub-module ads1274_acc_lane: one signed accumulator with add-enable, clear and scaled-output tap. Instantiate 4×, or generate; the shared adder alternative keeps it a single module.
- No other sub-modules.

Test Plan:
- LOG2_N=2, four frames all channels {+100,-100,0x7FFFFF,-0x800000}, spacing 10 cycles -> single OutValid 5 cycles after 4th InValid; DataOut = same four values; FrameCount returns to 0.
- LOG2_N=2, ch0 frames {1,2,3,4} -> ch0 out 2 (10>>>2). Ch1 frames {-1,-2,-3,-4} -> ch1 out -3 (-10>>>2 = -3, rounds toward -inf).
- LOG2_N=0, frame 0x000001_FFFFFF_800000_7FFFFF (ch3..ch0) -> identical DataOut, OutValid at t+5, every frame.
- Overrun: second InValid 3 cycles after first -> second frame ignored (sum excludes it), Overrun=1 and stays 1 across following windows until nReset.
- Clear after 3 of 4 frames (LOG2_N=2), then 4 frames of +8 -> exactly one OutValid, output 8 (pre-Clear data discarded); DataOut unchanged until then.
- nReset asserted during ACC ch2 -> all outputs 0 immediately. After release, 16 frames of value 5 (LOG2_N=4) -> output 5.
